vvp_shacc: RTL and testbench



---
 rtl/vvp_pkg.sv | 43 ++++
 rtl/vvp_shacc_outreg.sv | 49 ++++
 rtl/vvp_shacc.sv | 121 ++++++++++++
 tb/tb_vvp_shacc.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vvp_pkg.sv
// vvp_pkg: shared constants, types and helpers for the vvp accumulation path.
//   IW_DEF / OW_DEF / CW_DEF : default partial-sum, accumulator and counter widths
//   psum_t / acc_t           : signed partial-sum and accumulator types at defaults
//   sat_add                  : wide signed add with clamp to an ow-bit range,
//                              used when VVP_SHACC_SAT_EN is defined
package vvp_pkg;

  localparam int IW_DEF = 8;
  localparam int OW_DEF = 32;
  localparam int CW_DEF = 6;

  // Working width of sat_add; the clamp range must fit with headroom,
  // so accumulators up to 62 bits are supported by the saturating build.
  localparam int SAT_W = 64;

  typedef logic signed [IW_DEF-1:0] psum_t;
  typedef logic signed [OW_DEF-1:0] acc_t;

  // a + b evaluated at SAT_W bits, clamped to [-(2^(ow-1)), 2^(ow-1)-1].
  function automatic logic signed [SAT_W-1:0] sat_add(
    input  logic signed [SAT_W-1:0] a,
    input  logic signed [SAT_W-1:0] b,
    input  int                      ow,
    output logic                    clamped
  );
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sum     = a + b;
    hi      = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (ow - 1));
    clamped = 1'b0;
    sat_add = sum;
    if (sum > hi) begin
      sat_add = hi;
      clamped = 1'b1;
    end else if (sum < lo) begin
      sat_add = lo;
      clamped = 1'b1;
    end
  endfunction

endpackage

// File: rtl/vvp_shacc_outreg.sv
// vvp_shacc_outreg: single-entry valid/ready result register.
//   clk, rst_n            : clock, asynchronous active-low reset
//   load                  : capture load_data/load_nbits/load_sat this edge
//   load_data/nbits/sat   : result fields to capture
//   out_ready             : consumer accepts the held result
//   out_valid/data/nbits/sat : held result
//   in_ready              : register can take a new result this cycle
module vvp_shacc_outreg
  import vvp_pkg::*;
#(
  parameter int OW = OW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic signed [OW-1:0] load_data,
  input  logic [CW-1:0]        load_nbits,
  input  logic                 load_sat,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic signed [OW-1:0] out_data,
  output logic [CW-1:0]        out_nbits,
  output logic                 out_sat,
  output logic                 in_ready
);

  // Free when empty or being drained this cycle; independent of the producer.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_nbits <= '0;
      out_sat   <= 1'b0;
    end else if (load) begin
      // Reload wins over drain so back-to-back results leave no bubble.
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_nbits <= load_nbits;
      out_sat   <= load_sat;
    end else if (out_ready) begin
      // Data fields keep their stale value after a drain.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/vvp_shacc.sv
// vvp_shacc: bit-serial shift-accumulator behind the vvp dot-product stage.
// Combines signed per-plane partial sums MSB-first (acc = 2*acc + term) and
// hands the finished result to a single-entry valid/ready output register.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   in_valid/in_ready             : partial-sum beat handshake
//   in_data                       : signed partial sum (IW bits)
//   in_first/in_last              : MSB plane / LSB plane markers
//   in_neg                        : subtract this plane
//   out_valid/out_ready           : result handshake
//   out_data                      : signed result (OW bits)
//   out_nbits                     : plane count, saturating at 2^CW-1
//   out_sat                       : result was clamped
// Build option: define VVP_SHACC_SAT_EN to clamp each update to the signed
// OW-bit range and report clamping on out_sat; otherwise updates wrap and
// out_sat stays 0.
module vvp_shacc
  import vvp_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int OW = OW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [IW-1:0] in_data,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic                 in_neg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_data,
  output logic [CW-1:0]        out_nbits,
  output logic                 out_sat
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic signed [OW-1:0] acc;
  logic signed [OW-1:0] acc_nx;
  logic signed [OW-1:0] data_ext;
  logic signed [OW-1:0] term;
  logic signed [OW-1:0] base;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nx;
  logic                 sat_nx;
  logic                 accept;

  assign accept = in_valid && in_ready;

  // Extend before negating so the most negative IW value negates exactly.
  assign data_ext = {{(OW-IW){in_data[IW-1]}}, in_data};
  assign term     = in_neg ? -data_ext : data_ext;

  // A first beat starts from zero regardless of any leftover state.
  assign base   = in_first ? '0 : acc;
  assign cnt_nx = in_first ? CW'(1) : ((cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1);

`ifdef VVP_SHACC_SAT_EN
  logic                    sat_reg;
  logic                    clamped;
  logic signed [SAT_W-1:0] wide_sum;

  always_comb begin
    clamped  = 1'b0;
    wide_sum = sat_add({{(SAT_W-OW){base[OW-1]}}, base} <<< 1,
                       {{(SAT_W-OW){term[OW-1]}}, term}, OW, clamped);
    acc_nx   = wide_sum[OW-1:0];
    // Sticky within one result; a first beat drops the previous result's flag.
    sat_nx   = (in_first ? 1'b0 : sat_reg) | clamped;
  end
`else
  assign acc_nx = (base <<< 1) + term;
  assign sat_nx = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
`ifdef VVP_SHACC_SAT_EN
      sat_reg <= 1'b0;
`endif
    end else if (accept) begin
      if (in_last) begin
        // Result moves to the output register; accumulator returns to idle.
        acc <= '0;
        cnt <= '0;
`ifdef VVP_SHACC_SAT_EN
        sat_reg <= 1'b0;
`endif
      end else begin
        acc <= acc_nx;
        cnt <= cnt_nx;
`ifdef VVP_SHACC_SAT_EN
        sat_reg <= sat_nx;
`endif
      end
    end
  end

  vvp_shacc_outreg #(
    .OW (OW),
    .CW (CW)
  ) u_outreg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept && in_last),
    .load_data  (acc_nx),
    .load_nbits (cnt_nx),
    .load_sat   (sat_nx),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_nbits  (out_nbits),
    .out_sat    (out_sat),
    .in_ready   (in_ready)
  );

endmodule

// File: tb/tb_vvp_shacc.sv
// Bench for vvp_shacc: directed steps from the test plan followed by random
// multi-plane results, all drains checked against a weighted-sum reference.
module tb_vvp_shacc;

  localparam int IW = 8;
  localparam int OW = 32;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 in_valid, in_ready, in_first, in_last, in_neg;
  logic signed [IW-1:0] in_data;
  logic                 out_valid, out_ready, out_sat;
  logic signed [OW-1:0] out_data;
  logic [CW-1:0]        out_nbits;

  logic                 in8_valid, in8_ready, in8_first, in8_last, in8_neg;
  logic signed [IW-1:0] in8_data;
  logic                 out8_valid, out8_ready, out8_sat;
  logic signed [7:0]    out8_data;
  logic [CW-1:0]        out8_nbits;

  vvp_shacc #(.IW(IW), .OW(OW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_first(in_first), .in_last(in_last), .in_neg(in_neg),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_nbits(out_nbits), .out_sat(out_sat)
  );

  vvp_shacc #(.IW(IW), .OW(8), .CW(CW)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in8_valid), .in_ready(in8_ready), .in_data(in8_data),
    .in_first(in8_first), .in_last(in8_last), .in_neg(in8_neg),
    .out_valid(out8_valid), .out_ready(out8_ready), .out_data(out8_data),
    .out_nbits(out8_nbits), .out_sat(out8_sat)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit rand_ready = 1'b0;

  typedef struct {
    longint data;
    int     nbits;
    logic   sat;
  } res_t;

  res_t   sb[$];
  longint cur[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
  endtask

  // Reference: a result is the MSB-first weighted sum of its plane terms.
  function automatic res_t finish_result();
    res_t        r;
    longint      v;
    logic [31:0] lo;
    int          n;
    n = cur.size();
    v = 0;
    r.sat = 1'b0;
`ifdef VVP_SHACC_SAT_EN
    foreach (cur[i]) begin
      v = 2 * v + cur[i];
      if (v > 64'sd2147483647) begin v = 64'sd2147483647; r.sat = 1'b1; end
      if (v < -64'sd2147483648) begin v = -64'sd2147483648; r.sat = 1'b1; end
    end
`else
    foreach (cur[i]) begin
      if (n - 1 - i < 62) v += cur[i] * (64'sd1 <<< (n - 1 - i));
    end
    lo = v[31:0];
    v  = longint'($signed(lo));
`endif
    r.data  = v;
    r.nbits = (n > 63) ? 63 : n;
    return r;
  endfunction

  // One cycle: settle, score drain and accepted beat, advance past the edge.
  task automatic tick(output bit acc_in);
    res_t   r;
    longint t;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    #1;
    acc_in = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("result_expected", 64'(sb.size()), 64'd1);
      else begin
        r = sb.pop_front();
        chk("res_data", out_data, r.data);
        chk("res_nbits", out_nbits, r.nbits);
        chk("res_sat", out_sat, r.sat);
      end
    end
    if (acc_in) begin
      t = longint'(in_data);
      if (in_neg) t = -t;
      if (in_first) cur.delete();
      cur.push_back(t);
      if (in_last) begin
        sb.push_back(finish_result());
        cur.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input bit f, input bit l, input bit n);
    bit a;
    int k;
    in_valid = 1'b1;
    in_data  = IW'(d);
    in_first = f;
    in_last  = l;
    in_neg   = n;
    k = 0;
    a = 1'b0;
    while (!a && k < 100) begin
      tick(a);
      k++;
    end
    if (!a) chk("beat_timeout", 64'(a), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    sb.delete();
    cur.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int np;
    in_valid = 0; in_data = 0; in_first = 0; in_last = 0; in_neg = 0;
    out_ready = 1;
    in8_valid = 0; in8_data = 0; in8_first = 0; in8_last = 0; in8_neg = 0;
    out8_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_nbits", out_nbits, 0);
    chk("reset_out_sat", out_sat, 0);
    chk("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-plane result.
    send(64, 1, 1, 0);
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 64);
    chk("single_nbits", out_nbits, 1);
    tick(a);
    chk("drain_valid", out_valid, 0);
    chk("drain_stale_data", out_data, 64);

    // Three planes, negative MSB plane, held by backpressure.
    out_ready = 0;
    send(5, 1, 0, 1);
    send(-3, 0, 0, 0);
    send(2, 0, 1, 0);
    chk("three_valid", out_valid, 1);
    chk("three_data", out_data, -24);
    chk("three_nbits", out_nbits, 3);

    in_valid = 1; in_data = 1; in_first = 1; in_last = 1; in_neg = 0;
    for (int i = 0; i < 5; i++) begin
      tick(a);
      chk("bp_accept", 64'(a), 0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_data", out_data, -24);
      chk("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    tick(a);
    chk("bp_release_accept", 64'(a), 1);
    in_valid = 0;
    chk("bp_next_data", out_data, 1);
    chk("bp_next_valid", out_valid, 1);

    // Back-to-back single-plane results.
    send(7, 1, 1, 0);
    chk("b2b_valid0", out_valid, 1);
    chk("b2b_data0", out_data, 7);
    send(-9, 1, 1, 0);
    chk("b2b_valid1", out_valid, 1);
    chk("b2b_data1", out_data, -9);
    tick(a);
    chk("b2b_idle", out_valid, 0);

    // Reset discards a pending result.
    out_ready = 0;
    send(3, 1, 1, 0);
    chk("pend_valid", out_valid, 1);
    do_reset();
    chk("pend_cleared_data", out_data, 0);
    out_ready = 1;

    // Reset mid-accumulation, then a fresh four-plane result.
    send(1, 1, 0, 0);
    send(0, 0, 0, 0);
    do_reset();
    send(1, 1, 0, 0);
    send(0, 0, 0, 0);
    send(1, 0, 0, 0);
    send(1, 0, 1, 0);
    chk("fresh_data", out_data, 11);
    chk("fresh_nbits", out_nbits, 4);
    tick(a);

    // Plane count saturates.
    send(0, 1, 0, 0);
    for (int i = 0; i < 63; i++) send(0, 0, 0, 0);
    send(1, 0, 1, 0);
    chk("nbits_sat", out_nbits, 63);
    chk("nbits_sat_data", out_data, 1);
    tick(a);

    // Narrow accumulator overflow: 2*64 + 64 = 192.
    in8_valid = 1; in8_data = 64; in8_first = 1; in8_last = 0;
    @(posedge clk);
    #1;
    in8_first = 0; in8_last = 1;
    @(posedge clk);
    #1;
    in8_valid = 0;
    chk("ow8_valid", out8_valid, 1);
    chk("ow8_nbits", out8_nbits, 2);
`ifdef VVP_SHACC_SAT_EN
    chk("ow8_data", out8_data, 127);
    chk("ow8_sat", out8_sat, 1);
`else
    chk("ow8_data", out8_data, -64);
    chk("ow8_sat", out8_sat, 0);
`endif

    // Random multi-plane results with random gaps and backpressure.
    rand_ready = 1'b1;
    for (int r = 0; r < 40; r++) begin
      np = $urandom_range(1, 6);
      for (int p = 0; p < np; p++) begin
        if ($urandom_range(0, 3) == 0) tick(a);
        send(int'($signed(8'($urandom_range(0, 255)))), p == 0, p == np - 1,
             (p == 0) && ($urandom_range(0, 1) == 1));
      end
    end
    rand_ready = 1'b0;
    out_ready = 1;
    repeat (4) tick(a);
    chk("scoreboard_drained", 64'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
